rr_arb_mux: RTL
===============

RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter N_CH, default 4: number of input channels; legal range 2..16.
REQ-002 Parameter DATAW, default 4: data width per channel; legal range >= 1.
REQ-003 Parameter MODE, default 0: 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
REQ-004 Derived constant CHW SHALL equal max(1, clog2(N_CH)).
REQ-005 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 in_valid  input  N_CH  per-channel request; bit i qualifies channel i.
REQ-008 in_data  input  N_CH*DATAW  packed data; channel i occupies bits [i*DATAW +: DATAW].
REQ-009 in_ready  output  N_CH  per-channel accept; at most one bit SHALL be high in any cycle.
REQ-010 out_valid  output  1  output register holds a valid word.
REQ-011 out_data  output  DATAW  registered data of the granted channel.
REQ-012 out_ch  output  CHW  index of the channel that supplied out_data.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 load_en SHALL equal (!out_valid || out_ready), evaluated combinationally.
REQ-015 Grant SHALL be one-hot or zero, and zero only when in_valid == 0.
REQ-016 MODE=0: search starts at channel (last_grant+1) mod N_CH and wraps upward; first valid channel wins.
REQ-017 MODE=1: lowest-index valid channel wins; last_grant SHALL still be tracked but not used.
REQ-018 in_ready[i] SHALL equal grant[i] && load_en; in_ready SHALL not depend on in_data.
REQ-019 Transfer on channel i occurs when in_valid[i] && in_ready[i] at a rising edge.
REQ-020 On a transfer, out_data, out_ch and last_grant SHALL load next edge; out_valid SHALL set to 1.
REQ-021 Latency from input transfer to out_valid SHALL be exactly 1 cycle.
REQ-022 If load_en is true and no channel is valid, out_valid SHALL clear to 0 on the next edge.
REQ-023 If out_valid && !out_ready, the following SHALL hold stable: out_data, out_ch, out_valid, last_grant; all in_ready SHALL be 0.
REQ-024 Output pop and new load in the same cycle SHALL yield back-to-back words with no bubble (full throughput, 1 word/cycle).
REQ-025 last_grant SHALL change only on a transfer; arbitration without transfer SHALL not advance it.
REQ-026 Wrap-around: with last_grant = N_CH-1, channel 0 SHALL have highest priority.
REQ-027 Starvation bound for MODE=0: a continuously valid channel SHALL be granted within N_CH transfers.
REQ-028 out_data SHALL be held when out_valid=0 (no combinational pass-through of in_data).

Reset
REQ-029 When rst_n=0 at an edge, the following SHALL be forced: out_valid=0, out_data=0, out_ch=0, last_grant=N_CH-1.
REQ-030 While rst_n=0, in_ready SHALL be 0.
REQ-031 Reset mid-transfer SHALL discard the held word; no word SHALL emerge after reset deasserts unless newly accepted.
REQ-032 First grant after reset SHALL go to the lowest valid channel in both modes.

Verification (N_CH=4, DATAW=4)
REQ-033 Reset, then in_valid=4'b1111, data ch0..3 = 1,2,3,4, out_ready=1 held -> out_ch sequence 0,1,2,3,0 on consecutive cycles; out_data 1,2,3,4,1.
REQ-034 MODE=0, out_valid=1 with out_data=3, out_ready=0 for 3 cycles, in_valid=4'b0110 -> out_data stays 3; in_ready=0 for all 3 cycles; after out_ready=1 the next grant follows last_grant.
REQ-035 last_grant=3, in_valid=4'b1001 -> grant ch0, then ch3, then ch0 (wrap).
REQ-036 MODE=1, in_valid=4'b1010 held, out_ready=1 -> every output is out_ch=1; ch3 never granted.
REQ-037 Single transfer on ch2 (data 4'hA), then in_valid=0, out_ready=1 -> out_valid=1 for one cycle with data 4'hA, then 0.
REQ-038 rst_n=0 asserted while out_valid=1 and out_ready=0 -> next edge out_valid=0, out_data=0; after release with in_valid=4'b0100, ch2 is granted first.

Source files
------------

// File: rtl/rr_arb_mux.sv
// N_CH-way arbiter feeding a single registered output stage.
// Round-robin or fixed-priority grant, full-throughput valid/ready.
module rr_arb_mux #(
  parameter int N_CH  = 4,
  parameter int DATAW = 4,
  parameter int MODE  = 0,
  localparam int CHW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*DATAW-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [DATAW-1:0]      out_data,
  output logic [CHW-1:0]        out_ch,
  input  logic                  out_ready
);

  logic [CHW-1:0]   last_grant;
  logic [N_CH-1:0]  grant;
  logic [CHW-1:0]   gnt_idx;
  logic             found;
  logic [CHW:0]     sum;
  logic [CHW-1:0]   ridx;
  logic [DATAW-1:0] sel_data;
  logic             load_en;

  assign load_en = !out_valid || out_ready;

  // Grant depends only on in_valid and last_grant, never on in_data.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    ridx    = '0;
    if (MODE == 1) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!found && in_valid[k]) begin
          grant[k] = 1'b1;
          gnt_idx  = CHW'(k);
          found    = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= N_CH; k++) begin
        sum = {1'b0, last_grant} + (CHW+1)'(k);
        if (sum >= (CHW+1)'(N_CH))
          sum = sum - (CHW+1)'(N_CH);
        ridx = sum[CHW-1:0];
        if (!found && in_valid[ridx]) begin
          grant[ridx] = 1'b1;
          gnt_idx     = ridx;
          found       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant[k])
        sel_data = in_data[k*DATAW +: DATAW];
    end
  end

  assign in_ready = (rst_n && load_en) ? grant : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      last_grant <= CHW'(N_CH - 1);
    end else if (load_en) begin
      if (found) begin
        out_valid  <= 1'b1;
        out_data   <= sel_data;
        out_ch     <= gnt_idx;
        last_grant <= gnt_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule
